// File: rtl/endstop_event_arbiter_pkg.sv
// Shared definitions for the endstop event arbiter: FSM encoding,
// event counter width and default clear-wait limit.
package endstop_event_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESENT  = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_t;

  localparam int EV_COUNT_W       = 16;
  localparam int WAIT_MAX_DEFAULT = 15;

endpackage

// File: rtl/endstop_event_arbiter_if.sv
// Host-side event port: valid/ready handshake carrying the captured
// channel index, debounced level and position.
interface endstop_event_arbiter_if #(
  parameter int NCH = 4,
  parameter int PW  = 32
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          ev_valid;
  logic          ev_ready;
  logic [CW-1:0] ev_chan;
  logic          ev_level;
  logic [PW-1:0] ev_pos;

  // Arbiter side: produces events, consumes ready.
  modport master (
    output ev_valid, ev_chan, ev_level, ev_pos,
    input  ev_ready
  );

  // Host side: consumes events, produces ready.
  modport slave (
    input  ev_valid, ev_chan, ev_level, ev_pos,
    output ev_ready
  );
endinterface

// File: rtl/endstop_event_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request
// bit searching upward from ptr+1, wrapping modulo NCH.
module endstop_event_arbiter_rr_pick #(
  parameter int NCH = 4,
  parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_any
);

  // Scan the NCH positions after ptr and keep the first requester found.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise the
    // no-request path would hold its old value and infer a latch.
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      if (!gnt_any && req[(int'(ptr) + k) % NCH]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'((int'(ptr) + k) % NCH);
      end
    end
  end

endmodule

// File: rtl/endstop_event_arbiter.sv
// Shares the host event path between NCH debounce channels: picks a
// pending change round-robin, presents it on a valid/ready port, then
// unlocks the channel and waits for its changed flag to drop.
module endstop_event_arbiter
  import endstop_event_arbiter_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int PW       = 32,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        enable_mask,
  input  logic [NCH-1:0]        ch_changed,
  input  logic [NCH-1:0]        ch_level,
  input  logic [NCH*PW-1:0]     ch_pos,
  output logic [NCH-1:0]        ch_unlock,
  endstop_event_arbiter_if.master ev,
  output logic [EV_COUNT_W-1:0] ev_count,
  output logic [NCH-1:0]        stuck_err,
  output logic                  busy
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW = $clog2(WAIT_MAX + 1);

  state_t                state;
  logic [CW-1:0]         rr_ptr;
  logic [CW-1:0]         grant_q;
  logic [WW-1:0]         wait_cnt;
  logic [WW-1:0]         wait_nxt;
  logic [NCH-1:0]        pending;
  logic [CW-1:0]         pick_idx;
  logic                  pick_any;

  logic                  ev_valid_q;
  logic [CW-1:0]         ev_chan_q;
  logic                  ev_level_q;
  logic [PW-1:0]         ev_pos_q;
  logic [EV_COUNT_W-1:0] ev_count_q;
  logic [NCH-1:0]        ch_unlock_q;
  logic [NCH-1:0]        stuck_q;

  // Stuck channels drop out of arbitration until the next reset.
  assign pending  = ch_changed & enable_mask & ~stuck_q;
  assign wait_nxt = wait_cnt + WW'(1);

  endstop_event_arbiter_rr_pick #(
    .NCH (NCH),
    .CW  (CW)
  ) u_rr_pick (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  // Event sequencer: capture, present until accepted, unlock, wait for clear.
  // NOTE: reset is asynchronous and active-low, so it sits in the
  // sensitivity list and aborts an event mid-flight without any unlock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rr_ptr      <= CW'(NCH - 1);
      grant_q     <= '0;
      wait_cnt    <= '0;
      ev_valid_q  <= 1'b0;
      ev_chan_q   <= '0;
      ev_level_q  <= 1'b0;
      ev_pos_q    <= '0;
      ev_count_q  <= '0;
      ch_unlock_q <= '0;
      stuck_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the pre-edge values regardless of statement order.
      case (state)
        ST_IDLE: begin
          ch_unlock_q <= '0;
          if (pick_any) begin
            grant_q    <= pick_idx;
            rr_ptr     <= pick_idx;
            ev_chan_q  <= pick_idx;
            ev_level_q <= ch_level[pick_idx];
            ev_pos_q   <= ch_pos[int'(pick_idx)*PW +: PW];
            ev_valid_q <= 1'b1;
            state      <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ev.ev_ready) begin
            ev_valid_q  <= 1'b0;
            ev_count_q  <= ev_count_q + EV_COUNT_W'(1);
            ch_unlock_q <= NCH'(1) << grant_q;
            wait_cnt    <= '0;
            state       <= ST_WAIT_CLR;
          end
        end
        ST_WAIT_CLR: begin
          ch_unlock_q <= '0;
          if (!ch_changed[grant_q]) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WW'(WAIT_MAX)) begin
              stuck_q[grant_q] <= 1'b1;
              state            <= ST_IDLE;
            end
          end
        end
        default: begin
          ch_unlock_q <= '0;
          ev_valid_q  <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_chan  = ev_chan_q;
  assign ev.ev_level = ev_level_q;
  assign ev.ev_pos   = ev_pos_q;
  assign ev_count    = ev_count_q;
  assign ch_unlock   = ch_unlock_q;
  assign stuck_err   = stuck_q;
  assign busy        = (state != ST_IDLE);

endmodule
